// File: rtl/audio_phrase_sequencer_pkg.sv
// Shared constants and state encoding for the number-to-speech phrase sequencer.
package audio_phrase_sequencer_pkg;

    localparam int         ADR_W      = 32;
    localparam logic [7:0] END_NUMBER = 8'd0;
    localparam logic [7:0] BPM_NUMBER = 8'd230;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOOKUP    = 3'd1;
    localparam logic [2:0] ST_CHECK     = 3'd2;
    localparam logic [2:0] ST_PLAY_REQ  = 3'd3;
    localparam logic [2:0] ST_PLAY_WAIT = 3'd4;
    localparam logic [2:0] ST_FINISH    = 3'd5;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        LOOKUP    = ST_LOOKUP,
        CHECK     = ST_CHECK,
        PLAY_REQ  = ST_PLAY_REQ,
        PLAY_WAIT = ST_PLAY_WAIT,
        FINISH    = ST_FINISH
    } state_e;

endpackage

// File: rtl/audio_phrase_sequencer.sv
// Walks audio_number_map one word at a time and hands each word to the SD playback
// engine with a start/done handshake until the map reports the end of the phrase.
module audio_phrase_sequencer
    import audio_phrase_sequencer_pkg::*;
#(
    parameter int          MAP_WAIT     = 2,
    parameter logic [31:0] PLAY_TIMEOUT = 32'd50_000_000,
    parameter int          MAX_WORDS    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             speak,
    input  logic [7:0]       speak_number,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [7:0]       map_number,
    input  logic [ADR_W-1:0] map_start_adr,
    input  logic [ADR_W-1:0] map_stop_adr,
    input  logic [7:0]       map_next_number,
    output logic             play_start,
    output logic [ADR_W-1:0] play_start_adr,
    output logic [ADR_W-1:0] play_stop_adr,
    input  logic             play_done
);

    state_e           state_q, state_d;
    logic [7:0]       map_number_q, map_number_d;
    logic [7:0]       next_num_q, next_num_d;
    logic [ADR_W-1:0] start_adr_q, start_adr_d;
    logic [ADR_W-1:0] stop_adr_q, stop_adr_d;
    logic [2:0]       word_cnt_q, word_cnt_d;
    logic [7:0]       lk_cnt_q, lk_cnt_d;
    logic [31:0]      tmo_q, tmo_d;
    logic             error_q, error_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            map_number_q <= '0;
            next_num_q   <= '0;
            start_adr_q  <= '0;
            stop_adr_q   <= '0;
            word_cnt_q   <= '0;
            lk_cnt_q     <= '0;
            tmo_q        <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            map_number_q <= map_number_d;
            next_num_q   <= next_num_d;
            start_adr_q  <= start_adr_d;
            stop_adr_q   <= stop_adr_d;
            word_cnt_q   <= word_cnt_d;
            lk_cnt_q     <= lk_cnt_d;
            tmo_q        <= tmo_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        map_number_d = map_number_q;
        next_num_d   = next_num_q;
        start_adr_d  = start_adr_q;
        stop_adr_d   = stop_adr_q;
        word_cnt_d   = word_cnt_q;
        lk_cnt_d     = lk_cnt_q;
        tmo_d        = tmo_q;
        error_d      = error_q;

        case (state_q)
            IDLE: begin
                if (speak) begin
                    map_number_d = speak_number;
                    error_d      = 1'b0;
                    word_cnt_d   = '0;
                    lk_cnt_d     = '0;
                    state_d      = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lk_cnt_q == 8'(MAP_WAIT - 1)) state_d = CHECK;
                else                              lk_cnt_d = lk_cnt_q + 8'd1;
            end
            CHECK: begin
                if (map_stop_adr == '0 || map_stop_adr <= map_start_adr) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end else begin
                    start_adr_d = map_start_adr;
                    stop_adr_d  = map_stop_adr;
                    next_num_d  = map_next_number;
                    word_cnt_d  = word_cnt_q + 3'd1;
                    state_d     = PLAY_REQ;
                end
            end
            PLAY_REQ: begin
                tmo_d   = '0;
                state_d = PLAY_WAIT;
            end
            PLAY_WAIT: begin
                if (tmo_q < PLAY_TIMEOUT) tmo_d = tmo_q + 32'd1;
                if (play_done) begin
                    if (next_num_q == END_NUMBER) begin
                        state_d = FINISH;
                    end else if (word_cnt_q == 3'(MAX_WORDS)) begin
                        error_d = 1'b1;
                        state_d = FINISH;
                    end else begin
                        map_number_d = next_num_q;
                        lk_cnt_d     = '0;
                        state_d      = LOOKUP;
                    end
                // tmo_q starts at 0 one cycle after play_start, so +2 puts done
                // exactly PLAY_TIMEOUT cycles after the play_start cycle.
                end else if (tmo_q + 32'd2 >= PLAY_TIMEOUT) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // FINISH is already ending the phrase; re-entering it would stretch done.
        if (abort && state_q != IDLE && state_q != FINISH) begin
            state_d = FINISH;
            error_d = error_q;
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == FINISH);
    assign play_start     = (state_q == PLAY_REQ);
    assign error          = error_q;
    assign map_number     = map_number_q;
    assign play_start_adr = start_adr_q;
    assign play_stop_adr  = stop_adr_q;

endmodule
